button_event_scheduler: RTL and testbench

BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

---
 rtl/button_event_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_button_event_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Queues debounced button press events (one pending flag per button) and
//   presents them one at a time on a valid/ready interface. Buttons are
//   granted round-robin. A sticky overflow flag records presses lost because
//   the button already had an event pending.
//
//   Optional auto-repeat is compiled in with `define BTN_AUTO_REPEAT_EN:
//   a held button produces repeat events (evt_repeat=1) after HOLD_CYCLES,
//   then every REPEAT_CYCLES until it is released.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   btn_level   debounced button levels, bit i = button i
//   btn_rise    single-cycle debounced rising-edge pulses
//   evt_ready   consumer accepts the presented event
//   ovf_clr     clears the overflow flag
//   evt_valid   event presented
//   evt_id      button index of the presented event
//   evt_repeat  presented event is an auto-repeat
//   pending     per-button pending flags
//   overflow    sticky lost-event flag
//
// FSM states
//   S_IDLE    | no event presented; grant a pending button if any
//   S_PRESENT | event held on the outputs until evt_ready
module button_event_scheduler #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_level,
  input  logic [3:0] btn_rise,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  output logic       evt_repeat,
  output logic [3:0] pending,
  output logic       overflow
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_pending;
  logic       r_overflow;
  logic [1:0] r_last;
  logic [1:0] r_evt_id;
  logic       r_evt_repeat;

  logic       w_found;
  logic [1:0] w_idx;
  logic [1:0] w_grant_id;
  logic       w_grant_en;
  logic       w_grant_rep;
  logic [3:0] w_grant_mask;
  logic [3:0] w_pend_keep;
  logic [3:0] w_rep_req;
  logic [3:0] w_rep_set;
  logic [3:0] w_tag;
  logic       w_ovf_set;

  // Round-robin search starting one past the last granted button.
  always_comb begin
    w_found    = 1'b0;
    w_idx      = r_last;
    w_grant_id = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_en   = 1'b1;
          w_state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (evt_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_grant_mask = w_grant_en ? (4'b0001 << w_grant_id) : 4'b0000;
  assign w_grant_rep  = w_tag[w_grant_id];

  // A rise on the button being granted this cycle re-pends it cleanly;
  // only a rise on a still-pending button counts as lost.
  assign w_pend_keep = r_pending & ~w_grant_mask;
  assign w_ovf_set   = |(btn_rise & w_pend_keep);
  // Repeat requests never overflow and lose to a same-cycle rise.
  assign w_rep_set   = w_rep_req & ~w_pend_keep & ~btn_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending    <= 4'b0000;
      r_overflow   <= 1'b0;
      r_last       <= 2'd3;
      r_evt_id     <= 2'd0;
      r_evt_repeat <= 1'b0;
    end else begin
      r_pending  <= w_pend_keep | btn_rise | w_rep_set;
      // Set wins over a simultaneous clear.
      r_overflow <= w_ovf_set | (r_overflow & ~ovf_clr);
      if (w_grant_en) begin
        r_last       <= w_grant_id;
        r_evt_id     <= w_grant_id;
        r_evt_repeat <= w_grant_rep;
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  logic        r_arm;
  logic [1:0]  r_arm_id;
  logic [31:0] r_hold_cnt;
  logic        r_first_done;
  logic [3:0]  r_tag;
  logic [31:0] w_limit;
  logic        w_new_press;
  logic        w_hit;

  assign w_limit     = r_first_done ? 32'(REPEAT_CYCLES - 1) : 32'(HOLD_CYCLES - 1);
  assign w_new_press = w_grant_en && !w_grant_rep;
  assign w_hit       = r_arm && btn_level[r_arm_id] && (r_hold_cnt == w_limit);
  assign w_rep_req   = (w_hit && !w_new_press) ? (4'b0001 << r_arm_id) : 4'b0000;
  assign w_tag       = r_tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_arm        <= 1'b0;
      r_arm_id     <= 2'd0;
      r_hold_cnt   <= 32'd0;
      r_first_done <= 1'b0;
      r_tag        <= 4'b0000;
    end else begin
      r_tag <= (r_tag & w_pend_keep & ~btn_rise) | w_rep_set;
      if (w_new_press) begin
        r_arm        <= 1'b1;
        r_arm_id     <= w_grant_id;
        r_hold_cnt   <= 32'd0;
        r_first_done <= 1'b0;
      end else if (r_arm) begin
        if (!btn_level[r_arm_id]) begin
          r_arm        <= 1'b0;
          r_hold_cnt   <= 32'd0;
          r_first_done <= 1'b0;
        end else if (r_hold_cnt == w_limit) begin
          r_hold_cnt   <= 32'd0;
          r_first_done <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + 32'd1;
        end
      end
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{btn_level, HOLD_CYCLES[0], REPEAT_CYCLES[0]};
  assign w_rep_req = 4'b0000;
  assign w_tag     = 4'b0000;
`endif

  assign evt_valid  = (r_state == S_PRESENT);
  assign evt_id     = r_evt_id;
  assign evt_repeat = r_evt_repeat;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_button_event_scheduler.sv
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_q[$];

  always #5 clk = ~clk;

  button_event_scheduler #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_rise(btn_rise),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_repeat(evt_repeat), .pending(pending),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records an accepted event, then advances one clock and settles.
  task automatic tick();
    if (evt_valid && evt_ready) ev_q.push_back(int'(evt_id) + 4 * int'(evt_repeat));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_level = '0; btn_rise = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ev_q.delete();
  endtask

  initial begin
    int n_rep;
    int n_at_release;

    // Reset state
    do_reset();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_rep", 32'(evt_repeat), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_ovf", 32'(overflow), 0);

    // Single rise on button 2, two-cycle latency
    evt_ready = 1'b1; btn_rise = 4'b0100;
    tick(); btn_rise = '0;
    check("t1_pend", 32'(pending), 32'h4);
    check("t1_valid0", 32'(evt_valid), 0);
    tick();
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_id", 32'(evt_id), 2);
    check("t1_rep", 32'(evt_repeat), 0);
    check("t1_pend0", 32'(pending), 0);
    tick();
    check("t1_drop", 32'(evt_valid), 0);

    // All four rise together: round-robin from 0
    do_reset();
    evt_ready = 1'b1; btn_rise = 4'b1111;
    tick(); btn_rise = '0;
    for (int i = 0; i < 12; i++) tick();
    check("rr_count", 32'(ev_q.size()), 4);
    if (ev_q.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 32'(ev_q[i]), 32'(i));
    check("rr_ovf", 32'(overflow), 0);

    // Overflow on repeated rise of a pending button, sticky until clear
    do_reset();
    btn_rise = 4'b0011;
    tick(); btn_rise = '0;
    tick();
    check("ov_present", 32'(evt_valid), 1);
    check("ov_pend", 32'(pending), 32'h2);
    btn_rise = 4'b0010;
    tick(); btn_rise = '0;
    check("ov_set", 32'(overflow), 1);
    check("ov_pend1", 32'(pending), 32'h2);
    tick();
    check("ov_sticky", 32'(overflow), 1);
    btn_rise = 4'b0010; ovf_clr = 1'b1;
    tick(); btn_rise = '0; ovf_clr = 1'b0;
    check("ov_set_wins", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    check("ov_clr", 32'(overflow), 0);

    // Rise during the grant cycle re-pends without overflow
    do_reset();
    evt_ready = 1'b1; btn_rise = 4'b0001;
    tick();
    tick(); btn_rise = '0;
    check("rg_valid", 32'(evt_valid), 1);
    check("rg_pend", 32'(pending), 32'h1);
    check("rg_ovf", 32'(overflow), 0);

    // Backpressure: held stable for 10 cycles
    do_reset();
    btn_rise = 4'b1000;
    tick(); btn_rise = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(evt_valid), 1);
      check($sformatf("bp_id%0d", i), 32'(evt_id), 3);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    check("bp_drop", 32'(evt_valid), 0);
    check("bp_count", 32'(ev_q.size()), 1);

    // Reset during PRESENT drops everything
    do_reset();
    btn_rise = 4'b0111;
    tick(); btn_rise = '0;
    tick();
    check("rp_valid", 32'(evt_valid), 1);
    check("rp_id", 32'(evt_id), 0);
    check("rp_pend", 32'(pending), 32'h6);
    rst_n = 1'b0;
    tick();
    check("rp_r_valid", 32'(evt_valid), 0);
    check("rp_r_id", 32'(evt_id), 0);
    check("rp_r_pend", 32'(pending), 0);
    check("rp_r_ovf", 32'(overflow), 0);
    rst_n = 1'b1; evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rp_no_evt", 32'(ev_q.size()), 0);
    check("rp_idle", 32'(evt_valid), 0);

    // Button 0 held: auto-repeat when compiled in, single event otherwise
    do_reset();
    evt_ready = 1'b1; btn_level = 4'b0001; btn_rise = 4'b0001;
    tick(); btn_rise = '0;
    for (int i = 0; i < 40; i++) tick();
    btn_level = '0;
    tick(); tick(); tick();
    n_at_release = ev_q.size();
    for (int i = 0; i < 20; i++) tick();
    n_rep = 0;
    foreach (ev_q[i]) if (ev_q[i] >= 4) n_rep++;
    check("ar_first", 32'(ev_q[0]), 0);
    check("ar_stop", 32'(ev_q.size()), 32'(n_at_release));
`ifdef BTN_AUTO_REPEAT_EN
    check("ar_repeats", 32'(n_rep >= 5), 1);
    check("ar_all_rep", 32'(n_rep), 32'(ev_q.size() - 1));
`else
    check("ar_count", 32'(ev_q.size()), 1);
    check("ar_norep", 32'(n_rep), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
